// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - start/wait/write sequencer for the shared mult/div units and HI/LO registers
// Moore FSM: every output decodes from state_q and op_q only.
module muldiv_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic op,
  input  logic mult_fim,
  input  logic div_fim,
  input  logic div_by_zero,
  output logic mult_start,
  output logic div_start,
  output logic hi_sel,
  output logic lo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic busy,
  output logic done,
  output logic exc_div0,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_EXC   = 3'd4,
    S_TOUT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            unit_fim;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the unit that was started may complete the operation.
  assign unit_fim = op_q ? div_fim : mult_fim;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Divide-by-zero outranks completion; a late done still beats timeout.
        if (op_q && div_by_zero) begin
          state_d = S_EXC;
        end else if (unit_fim) begin
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE, S_EXC, S_TOUT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_sel     = 1'b0;
    lo_sel     = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    exc_div0   = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      S_START: begin
        busy       = 1'b1;
        hi_sel     = op_q;
        lo_sel     = op_q;
        mult_start = ~op_q;
        div_start  = op_q;
      end
      S_WAIT: begin
        busy   = 1'b1;
        hi_sel = op_q;
        lo_sel = op_q;
      end
      S_WRITE: begin
        busy     = 1'b1;
        hi_sel   = op_q;
        lo_sel   = op_q;
        hi_write = 1'b1;
        lo_write = 1'b1;
        done     = 1'b1;
      end
      S_EXC: begin
        busy     = 1'b1;
        hi_sel   = op_q;
        lo_sel   = op_q;
        exc_div0 = 1'b1;
      end
      S_TOUT: begin
        busy    = 1'b1;
        hi_sel  = op_q;
        lo_sel  = op_q;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - table-driven and randomized checks of muldiv_sequencer
// dut 0 uses TIMEOUT=64, dut 1 uses TIMEOUT=8.
module tb_muldiv_sequencer;

  localparam int K_WRITE = 0;
  localparam int K_EXC   = 1;
  localparam int K_TOUT  = 2;

  logic clock;
  logic reset;
  logic req_s [2];
  logic op_s [2];
  logic mfim_s [2];
  logic dfim_s [2];
  logic dbz_s [2];
  logic ms [2], ds [2], hs [2], ls [2], hw [2], lw [2];
  logic bz [2], dn [2], ex [2], to [2];

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  muldiv_sequencer u_d64 (
    .clock(clock), .reset(reset), .req(req_s[0]), .op(op_s[0]),
    .mult_fim(mfim_s[0]), .div_fim(dfim_s[0]), .div_by_zero(dbz_s[0]),
    .mult_start(ms[0]), .div_start(ds[0]), .hi_sel(hs[0]), .lo_sel(ls[0]),
    .hi_write(hw[0]), .lo_write(lw[0]), .busy(bz[0]), .done(dn[0]),
    .exc_div0(ex[0]), .timeout(to[0])
  );

  muldiv_sequencer #(.TIMEOUT(8)) u_d8 (
    .clock(clock), .reset(reset), .req(req_s[1]), .op(op_s[1]),
    .mult_fim(mfim_s[1]), .div_fim(dfim_s[1]), .div_by_zero(dbz_s[1]),
    .mult_start(ms[1]), .div_start(ds[1]), .hi_sel(hs[1]), .lo_sel(ls[1]),
    .hi_write(hw[1]), .lo_write(lw[1]), .busy(bz[1]), .done(dn[1]),
    .exc_div0(ex[1]), .timeout(to[1])
  );

  // {mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write, busy, done, exc_div0, timeout}
  function automatic logic [9:0] obs(input int d);
    return {ms[d], ds[d], hs[d], ls[d], hw[d], lw[d], bz[d], dn[d], ex[d], to[d]};
  endfunction

  // Expected outputs c cycles after the accepting edge, for w WAIT cycles and outcome k.
  function automatic logic [9:0] exp_obs(input int c, input bit o, input int w, input int k);
    if (c == 1)              return {~o, o, o, o, 6'b001000};
    if (c >= 2 && c <= w + 1) return {1'b0, 1'b0, o, o, 6'b001000};
    if (c == w + 2) begin
      if (k == K_WRITE) return {1'b0, 1'b0, o, o, 6'b111100};
      if (k == K_EXC)   return {1'b0, 1'b0, o, o, 6'b001010};
      return {1'b0, 1'b0, o, o, 6'b001001};
    end
    return 10'b0;
  endfunction

  // Reference: scan WAIT cycles in order, divide-by-zero first, then done, else time out.
  task automatic model(input bit o, input int t, input int fa, input int da,
                       output int w, output int k);
    for (int j = 1; j <= t; j++) begin
      if (o && da == j) begin w = j; k = K_EXC; return; end
      if (fa == j)      begin w = j; k = K_WRITE; return; end
    end
    w = t;
    k = K_TOUT;
  endtask

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic clear_inputs(input int d);
    req_s[d] = 1'b0; op_s[d] = 1'b0; mfim_s[d] = 1'b0; dfim_s[d] = 1'b0; dbz_s[d] = 1'b0;
  endtask

  // rq: 0 = req low while busy, 1 = req held high while busy, 2 = random req while busy.
  task automatic run_txn(input string nm, input int d, input bit o, input int fa,
                         input int da, input int sa, input int rq, input int w, input int k);
    bit f, s, z;
    @(negedge clock);
    chk($sformatf("%s_idle_pre", nm), obs(d), 10'b0);
    req_s[d] = 1'b1;
    op_s[d]  = o;
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clock);
      chk($sformatf("%s_c%0d", nm, c), obs(d), exp_obs(c, o, w, k));
      f = (c >= 2) && (fa == c - 1);
      s = (c >= 2) && (sa == c - 1);
      z = (c >= 2) && (da == c - 1);
      mfim_s[d] = o ? s : f;
      dfim_s[d] = o ? f : s;
      dbz_s[d]  = z;
      op_s[d]   = ~o;
      if (c <= w + 2) req_s[d] = (rq == 1) ? 1'b1 : (rq == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      else            req_s[d] = 1'b0;
    end
    clear_inputs(d);
  endtask

  typedef struct {
    string nm;
    int    d;
    bit    op;
    int    fim_at;
    int    dbz_at;
    int    stray_at;
    int    rq;
    int    exp_w;
    int    exp_k;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int w, k, d, t, fa, da, sa;
    bit o;

    vecs[0] = '{"mult33",     0, 1'b0, 33, 0, 0, 1, 33, K_WRITE};
    vecs[1] = '{"div10",      0, 1'b1, 10, 0, 4, 0, 10, K_WRITE};
    vecs[2] = '{"div0",       0, 1'b1,  3, 3, 0, 0,  3, K_EXC};
    vecs[3] = '{"tout8",      1, 1'b0,  0, 0, 0, 0,  8, K_TOUT};
    vecs[4] = '{"late_done",  1, 1'b0,  8, 0, 0, 1,  8, K_WRITE};
    vecs[5] = '{"too_late",   1, 1'b0,  9, 0, 0, 0,  8, K_TOUT};
    vecs[6] = '{"min_lat",    0, 1'b0,  1, 0, 0, 1,  1, K_WRITE};
    vecs[7] = '{"mult_dbz",   1, 1'b0,  5, 2, 0, 0,  5, K_WRITE};
    vecs[8] = '{"div_stray",  1, 1'b1,  0, 0, 3, 0,  8, K_TOUT};
    vecs[9] = '{"div0_last",  1, 1'b1,  0, 8, 0, 1,  8, K_EXC};

    clear_inputs(0);
    clear_inputs(1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_d64", obs(0), 10'b0);
    chk("reset_d8", obs(1), 10'b0);
    reset = 1'b1;

    foreach (vecs[i])
      run_txn(vecs[i].nm, vecs[i].d, vecs[i].op, vecs[i].fim_at, vecs[i].dbz_at,
              vecs[i].stray_at, vecs[i].rq, vecs[i].exp_w, vecs[i].exp_k);

    // Reset pulse in the middle of WAIT, with req high at the reset edge.
    @(negedge clock);
    req_s[0] = 1'b1; op_s[0] = 1'b1;
    @(negedge clock);
    req_s[0] = 1'b0;
    repeat (5) @(negedge clock);
    chk("mid_wait_busy", obs(0), {4'b0011, 6'b001000});
    reset = 1'b0;
    req_s[0] = 1'b1;
    @(negedge clock);
    chk("after_reset", obs(0), 10'b0);
    reset = 1'b1;
    req_s[0] = 1'b0;
    @(negedge clock);
    chk("after_reset_idle", obs(0), 10'b0);
    run_txn("post_reset", 0, 1'b0, 2, 0, 0, 0, 2, K_WRITE);

    for (int n = 0; n < 40; n++) begin
      d  = int'($urandom_range(0, 1));
      t  = (d == 0) ? 64 : 8;
      o  = 1'($urandom_range(0, 1));
      fa = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, t + 2));
      da = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, t + 2)) : 0;
      sa = int'($urandom_range(0, t));
      model(o, t, fa, da, w, k);
      run_txn($sformatf("rnd%0d", n), d, o, fa, da, sa, 2, w, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
